// File: rtl/instruction_fetch_stage_pkg.sv
// Processor-wide definitions shared by fetch, decode and control.
// Holds the instruction word type, opcode field positions, the bubble
// encoding and small helpers for recognising a jump and extracting its target.
package instruction_fetch_stage_pkg;

  localparam int INSTR_WIDTH       = 8;
  localparam int JUMP_BIT          = 7;
  localparam int OPCODE_MSB        = 7;  // bit 7 selects ALU op vs jump
  localparam int OPCODE_LSB        = 7;
  localparam int JUMP_TARGET_WIDTH = 6;
  localparam int JUMP_TARGET_LSB   = 0;

  typedef logic [INSTR_WIDTH-1:0]       instr_t;
  typedef logic [JUMP_TARGET_WIDTH-1:0] jump_target_t;

  // A jump-class word with target 0: main control decodes it as
  // non-register-writing, and it is never acted on because IF/ID marks it invalid.
  localparam instr_t BUBBLE_INSTR = 8'h80;

  function automatic logic is_jump(input instr_t instr);
    return instr[JUMP_BIT];
  endfunction

  function automatic jump_target_t jump_target(input instr_t instr);
    return instr[JUMP_TARGET_LSB +: JUMP_TARGET_WIDTH];
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Bundle between the fetch stage and its surroundings.
//   master : drives Stall and the instruction-memory load port, observes fetch state
//   slave  : the fetch stage itself
interface instruction_fetch_stage_if #(
  parameter int PC_WIDTH   = 8,
  parameter int IMEM_DEPTH = 64
);
  import instruction_fetch_stage_pkg::*;

  localparam int ADDR_WIDTH = $clog2(IMEM_DEPTH);

  logic                  Stall;
  logic                  Load_En;
  logic [ADDR_WIDTH-1:0] Load_Addr;
  instr_t                Load_Data;
  logic [PC_WIDTH-1:0]   Fetch_PC;
  instr_t                Instruction_Code;
  logic [PC_WIDTH-1:0]   IFID_PC;
  logic                  IFID_Valid;
  logic                  Jump_Taken;

  modport master (
    output Stall, Load_En, Load_Addr, Load_Data,
    input  Fetch_PC, Instruction_Code, IFID_PC, IFID_Valid, Jump_Taken
  );

  modport slave (
    input  Stall, Load_En, Load_Addr, Load_Data,
    output Fetch_PC, Instruction_Code, IFID_PC, IFID_Valid, Jump_Taken
  );
endinterface

// File: rtl/instruction_fetch_stage_instruction_memory.sv
// Instruction memory: IMEM_DEPTH x 8 words.
//   clk, wr_en, wr_addr, wr_data : synchronous write port
//   rd_addr (full PC width)      : asynchronous read port
//   rd_data                      : word at rd_addr (bubble when out of range)
//   rd_out_of_range              : rd_addr >= IMEM_DEPTH
module instruction_memory
  import instruction_fetch_stage_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int IMEM_DEPTH = 64,
  localparam int ADDR_WIDTH = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  instr_t                wr_data,
  input  logic [PC_WIDTH-1:0]   rd_addr,
  output instr_t                rd_data,
  output logic                  rd_out_of_range
);

  instr_t mem [IMEM_DEPTH];

  // Contents are deliberately not reset so a program loaded during reset survives.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < IMEM_DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_out_of_range = (32'(rd_addr) >= IMEM_DEPTH);
  // Read is combinational, so a same-edge write is seen only on the next fetch.
  assign rd_data = rd_out_of_range ? BUBBLE_INSTR : mem[rd_addr[ADDR_WIDTH-1:0]];

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: program counter, instruction memory and IF/ID register.
//   Clk, Reset : clock and synchronous active-high reset
//   bus.slave  : Stall, memory load port in; Fetch_PC, IF/ID contents and
//                Jump_Taken out
// Jumps are resolved from the IF/ID register; the fetch made in the same cycle
// is replaced with a bubble, giving a one-cycle penalty.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int IMEM_DEPTH = 64,
  parameter int RESET_PC   = 0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  instruction_fetch_stage_if.slave bus
);

  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  instr_t              instr_reg, instr_next;
  logic [PC_WIDTH-1:0] ifid_pc_reg, ifid_pc_next;
  logic                ifid_valid_reg, ifid_valid_next;

  instr_t imem_rd_data;
  logic   imem_rd_oor;
  logic   jump_taken;

  instruction_memory #(
    .PC_WIDTH   (PC_WIDTH),
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk             (Clk),
    .wr_en           (bus.Load_En),
    .wr_addr         (bus.Load_Addr),
    .wr_data         (bus.Load_Data),
    .rd_addr         (pc_reg),
    .rd_data         (imem_rd_data),
    .rd_out_of_range (imem_rd_oor)
  );

  // Valid gating keeps a bubble (which carries the jump bit) from redirecting.
  assign jump_taken = ifid_valid_reg && is_jump(instr_reg) && !bus.Stall && !Reset;

  always_comb begin
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    ifid_pc_next    = ifid_pc_reg;
    ifid_valid_next = ifid_valid_reg;
    if (!bus.Stall) begin
      ifid_pc_next = pc_reg;
      if (jump_taken) begin
        pc_next         = PC_WIDTH'(jump_target(instr_reg));
        instr_next      = BUBBLE_INSTR;
        ifid_valid_next = 1'b0;
      end else begin
        pc_next = pc_reg + PC_WIDTH'(1);
        if (imem_rd_oor) begin
          instr_next      = BUBBLE_INSTR;
          ifid_valid_next = 1'b0;
        end else begin
          instr_next      = imem_rd_data;
          ifid_valid_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_reg         <= PC_WIDTH'(RESET_PC);
      instr_reg      <= BUBBLE_INSTR;
      ifid_pc_reg    <= '0;
      ifid_valid_reg <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_valid_reg <= ifid_valid_next;
    end
  end

  assign bus.Fetch_PC         = pc_reg;
  assign bus.Instruction_Code = instr_reg;
  assign bus.IFID_PC          = ifid_pc_reg;
  assign bus.IFID_Valid       = ifid_valid_reg;
  assign bus.Jump_Taken       = jump_taken;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;
  import instruction_fetch_stage_pkg::*;

  localparam int PCW   = 8;
  localparam int DEPTH = 64;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  instruction_fetch_stage_if #(.PC_WIDTH(PCW), .IMEM_DEPTH(DEPTH)) bus ();

  instruction_fetch_stage #(
    .PC_WIDTH   (PCW),
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (0)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  // Behavioural model: architectural state plus a copy of memory.
  int         m_pc;
  logic [7:0] m_instr;
  int         m_ifid_pc;
  bit         m_valid;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] image [DEPTH];
  logic [7:0] codes [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_jump();
    return m_valid && m_instr[7] && !bus.Stall && !Reset;
  endfunction

  // One clock edge of the fetch stage, stated as the architectural rules.
  task automatic model_update();
    bit j;
    int target;
    j = m_jump();
    target = int'(m_instr) % 64;
    if (Reset) begin
      m_pc = 0; m_instr = 8'h80; m_ifid_pc = 0; m_valid = 0;
    end else if (!bus.Stall) begin
      m_ifid_pc = m_pc;
      if (j) begin
        m_instr = 8'h80; m_valid = 0; m_pc = target;
      end else begin
        if (m_pc < DEPTH) begin m_instr = m_mem[m_pc]; m_valid = 1; end
        else begin m_instr = 8'h80; m_valid = 0; end
        m_pc = (m_pc + 1) % 256;
      end
    end
    if (bus.Load_En) m_mem[bus.Load_Addr] = bus.Load_Data;
  endtask

  // Per-cycle comparison against the model.
  always begin
    @(negedge Clk);
    #1;
    if (checking) begin
      chk("fetch_pc",   32'(bus.Fetch_PC),         32'(m_pc));
      chk("instr",      32'(bus.Instruction_Code), 32'(m_instr));
      chk("ifid_pc",    32'(bus.IFID_PC),          32'(m_ifid_pc));
      chk("ifid_valid", 32'(bus.IFID_Valid),       32'(m_valid));
      chk("jump_taken", 32'(bus.Jump_Taken),       32'(m_jump()));
    end
  end

  task automatic tick(input bit rst, input bit stl, input bit le,
                      input int la = 0, input logic [7:0] ld = 8'h00);
    Reset         = rst;
    bus.Stall     = stl;
    bus.Load_En   = le;
    bus.Load_Addr = 6'(la);
    bus.Load_Data = ld;
    @(posedge Clk);
    model_update();
    @(negedge Clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  initial begin
    Reset = 1'b1; bus.Stall = 1'b0; bus.Load_En = 1'b0;
    bus.Load_Addr = '0; bus.Load_Data = '0;
    codes[0] = 8'h0A; codes[1] = 8'h51; codes[2] = 8'h13; codes[3] = 8'h22;

    tick(1, 0, 0);
    checking = 1;

    // Preload the whole memory under reset; no jumps outside the directed ones.
    for (int a = 0; a < DEPTH; a++) begin
      if (a < 4) image[a] = codes[a];
      else if (a == 7) image[a] = 8'h07;
      else image[a] = 8'($urandom_range(0, 127));
      tick(1, 0, 1, a, image[a]);
    end
    chk("rst_fetch_pc", 32'(bus.Fetch_PC), 0);
    chk("rst_instr", 32'(bus.Instruction_Code), 32'h80);
    chk("rst_ifid_pc", 32'(bus.IFID_PC), 0);
    chk("rst_valid", 32'(bus.IFID_Valid), 0);
    chk("rst_jump", 32'(bus.Jump_Taken), 0);

    // Straight-line fetch after release.
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0);
      chk("seq_ifid_pc", 32'(bus.IFID_PC), 32'(k));
      chk("seq_instr", 32'(bus.Instruction_Code), 32'(codes[k]));
      chk("seq_valid", 32'(bus.IFID_Valid), 1);
    end

    // Jump at PC 2 to 5.
    tick(1, 0, 1, 2, 8'h85);
    image[5] = 8'h33;
    tick(1, 0, 1, 5, 8'h33);
    run(3);
    chk("jmp_ifid_pc", 32'(bus.IFID_PC), 2);
    chk("jmp_taken", 32'(bus.Jump_Taken), 1);
    tick(0, 0, 0);
    chk("jmp_bubble_pc", 32'(bus.IFID_PC), 3);
    chk("jmp_bubble_instr", 32'(bus.Instruction_Code), 32'h80);
    chk("jmp_bubble_valid", 32'(bus.IFID_Valid), 0);
    chk("jmp_taken_once", 32'(bus.Jump_Taken), 0);
    chk("jmp_fetch_pc", 32'(bus.Fetch_PC), 5);
    tick(0, 0, 0);
    chk("jmp_tgt_pc", 32'(bus.IFID_PC), 5);
    chk("jmp_tgt_instr", 32'(bus.Instruction_Code), 32'h33);
    chk("jmp_tgt_valid", 32'(bus.IFID_Valid), 1);

    // Stall three cycles at Fetch_PC 4.
    tick(1, 0, 1, 2, 8'h13);
    run(4);
    chk("stl_fetch_pc0", 32'(bus.Fetch_PC), 4);
    for (int s = 0; s < 3; s++) begin
      tick(0, 1, 0);
      chk("stl_fetch_pc", 32'(bus.Fetch_PC), 4);
      chk("stl_ifid_pc", 32'(bus.IFID_PC), 3);
      chk("stl_instr", 32'(bus.Instruction_Code), 32'(image[3]));
      chk("stl_valid", 32'(bus.IFID_Valid), 1);
    end
    tick(0, 0, 0);
    chk("stl_resume_pc", 32'(bus.IFID_PC), 4);
    chk("stl_resume_instr", 32'(bus.Instruction_Code), 32'(image[4]));
    chk("stl_resume_fetch", 32'(bus.Fetch_PC), 5);

    // Stall while IF/ID holds a jump.
    tick(1, 0, 1, 2, 8'h85);
    run(3);
    bus.Stall = 1'b1;
    #1;
    chk("sj_jump_stalled", 32'(bus.Jump_Taken), 0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    chk("sj_jump_held", 32'(bus.Jump_Taken), 0);
    chk("sj_ifid_held", 32'(bus.IFID_PC), 2);
    bus.Stall = 1'b0;
    #1;
    chk("sj_jump_release", 32'(bus.Jump_Taken), 1);
    tick(0, 0, 0);
    chk("sj_fetch_pc", 32'(bus.Fetch_PC), 5);
    chk("sj_valid", 32'(bus.IFID_Valid), 0);

    // Reset mid-run at Fetch_PC 9.
    tick(1, 0, 1, 2, 8'h13);
    run(9);
    chk("mr_fetch_pc9", 32'(bus.Fetch_PC), 9);
    tick(1, 0, 0);
    chk("mr_fetch_pc0", 32'(bus.Fetch_PC), 0);
    chk("mr_valid", 32'(bus.IFID_Valid), 0);
    tick(0, 0, 0);
    chk("mr_refetch", 32'(bus.Instruction_Code), 32'h0A);
    chk("mr_refetch_valid", 32'(bus.IFID_Valid), 1);

    // Run off the end of memory and wrap the PC.
    tick(1, 0, 0);
    run(65);
    chk("oor_ifid_pc", 32'(bus.IFID_PC), 64);
    chk("oor_instr", 32'(bus.Instruction_Code), 32'h80);
    chk("oor_valid", 32'(bus.IFID_Valid), 0);
    chk("oor_fetch_pc", 32'(bus.Fetch_PC), 65);
    run(191);
    chk("wrap_fetch_pc", 32'(bus.Fetch_PC), 0);
    tick(0, 0, 0);
    chk("wrap_instr", 32'(bus.Instruction_Code), 32'h0A);
    chk("wrap_valid", 32'(bus.IFID_Valid), 1);

    // Load colliding with fetch of the same address.
    tick(1, 0, 0);
    run(7);
    chk("ld_fetch_pc", 32'(bus.Fetch_PC), 7);
    tick(0, 0, 1, 7, 8'h44);
    chk("ld_old_word", 32'(bus.Instruction_Code), 32'(image[7]));
    tick(1, 0, 0);
    run(8);
    chk("ld_new_pc", 32'(bus.IFID_PC), 7);
    chk("ld_new_word", 32'(bus.Instruction_Code), 32'h44);

    // Randomised traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0, int'($urandom_range(0, DEPTH - 1)),
           8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
